// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register plus result select.
// Drives the register-file write port, tracks halt and reports errors.
// Optional feature: define RETIRE_CNT_EN to add the CNT_W-bit retireCnt
// output counting retired instructions. The default build leaves it out.
module writeback_stage #(
    parameter int DATA_W = 16
`ifdef RETIRE_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] aluResIn,
    input  logic [DATA_W-1:0] memDataIn,
    input  logic [DATA_W-1:0] nextPcIn,
    input  logic              condIn,
    input  logic [15:0]       instrIn,
    input  logic              regWrtIn,
    input  logic [2:0]        writeRegIn,
    input  logic [2:0]        regWrtSrcIn,
    input  logic              haltIn,
    input  logic              errIn,
    output logic [DATA_W-1:0] regWrtData,
    output logic              regWrtEn,
    output logic [2:0]        regWrtAddr,
    output logic              halted,
    output logic              err,
    output logic              errSticky
`ifdef RETIRE_CNT_EN
    , output logic [CNT_W-1:0] retireCnt
`endif
);

    localparam logic [2:0] SRC_ALU   = 3'd0;
    localparam logic [2:0] SRC_MEM   = 3'd1;
    localparam logic [2:0] SRC_PC    = 3'd2;
    localparam logic [2:0] SRC_COND  = 3'd3;
    localparam logic [2:0] SRC_IMMHI = 3'd4;

    // MEM/WB register fields
    logic              valid_q;
    logic [DATA_W-1:0] alu_res_q;
    logic [DATA_W-1:0] mem_data_q;
    logic [DATA_W-1:0] next_pc_q;
    logic              cond_q;
    logic [7:0]        instr_lo_q;
    logic              reg_wrt_q;
    logic [2:0]        write_reg_q;
    logic [2:0]        reg_wrt_src_q;
    logic              halt_q;
    logic              err_in_q;

    // Status state
    logic              halted_q, halted_d;
    logic              err_sticky_q, err_sticky_d;

    // Result select signals
    logic [DATA_W-1:0] sel_data;
    logic              src_err;

    // Only the low instruction byte feeds the result (immediate-high select).
    logic              unused_instr_hi;
    assign unused_instr_hi = ^instrIn[15:8];

    // Pipeline register: halted beats flush beats stall beats load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            alu_res_q     <= '0;
            mem_data_q    <= '0;
            next_pc_q     <= '0;
            cond_q        <= 1'b0;
            instr_lo_q    <= '0;
            reg_wrt_q     <= 1'b0;
            write_reg_q   <= '0;
            reg_wrt_src_q <= '0;
            halt_q        <= 1'b0;
            err_in_q      <= 1'b0;
        end else if (halted_q || flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q       <= inValid;
            alu_res_q     <= aluResIn;
            mem_data_q    <= memDataIn;
            next_pc_q     <= nextPcIn;
            cond_q        <= condIn;
            instr_lo_q    <= instrIn[7:0];
            reg_wrt_q     <= regWrtIn;
            write_reg_q   <= writeRegIn;
            reg_wrt_src_q <= regWrtSrcIn;
            halt_q        <= haltIn;
            err_in_q      <= errIn;
        end
    end

    // Result mux on the registered select; codes 5-7 flag an error and yield 0.
    always_comb begin
        sel_data = '0;
        src_err  = 1'b0;
        case (reg_wrt_src_q)
            SRC_ALU:   sel_data = alu_res_q;
            SRC_MEM:   sel_data = mem_data_q;
            SRC_PC:    sel_data = next_pc_q;
            SRC_COND:  sel_data = {{(DATA_W-1){1'b0}}, cond_q};
            SRC_IMMHI: sel_data = DATA_W'({instr_lo_q, 8'h00});
            default:   src_err  = 1'b1;
        endcase
    end

    // Write port and error reporting; everything reads 0 while the slot is empty.
    always_comb begin
        regWrtData   = valid_q ? sel_data : '0;
        regWrtAddr   = valid_q ? write_reg_q : 3'd0;
        regWrtEn     = valid_q & reg_wrt_q & ~halt_q & ~src_err & ~halted_q;
        err          = valid_q & (err_in_q | src_err);
        halted_d     = halted_q | (valid_q & halt_q);
        err_sticky_d = err_sticky_q | err;
        errSticky    = err_sticky_q | err;
        halted       = halted_q;
    end

    // Sticky halt and error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q     <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            halted_q     <= halted_d;
            err_sticky_q <= err_sticky_d;
        end
    end

`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic             retire;

    // An instruction retires when it leaves WB: not held by stall (flush or a
    // retiring HALT also let it go), and nothing counts once halted.
    always_comb begin
        retire       = valid_q & ~halted_q & (~stall | flush | halt_q);
        retire_cnt_d = retire ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) retire_cnt_q <= '0;
        else     retire_cnt_q <= retire_cnt_d;
    end

    assign retireCnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed scenarios plus randomized traffic,
// checked by a scoreboard against a behavioural model of the stage.
module tb_writeback_stage;

    localparam int DATA_W = 16;
`ifdef RETIRE_CNT_EN
    localparam int CNT_W  = 4;
    localparam int OW     = DATA_W + 7 + CNT_W;
`else
    localparam int OW     = DATA_W + 7;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              inValid, stall, flush, condIn, regWrtIn, haltIn, errIn;
    logic [DATA_W-1:0] aluResIn, memDataIn, nextPcIn;
    logic [15:0]       instrIn;
    logic [2:0]        writeRegIn, regWrtSrcIn;
    logic [DATA_W-1:0] regWrtData;
    logic              regWrtEn, halted, err, errSticky;
    logic [2:0]        regWrtAddr;
`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0]  retireCnt;
`endif

    writeback_stage #(
        .DATA_W(DATA_W)
`ifdef RETIRE_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .stall(stall), .flush(flush),
        .aluResIn(aluResIn), .memDataIn(memDataIn), .nextPcIn(nextPcIn),
        .condIn(condIn), .instrIn(instrIn), .regWrtIn(regWrtIn),
        .writeRegIn(writeRegIn), .regWrtSrcIn(regWrtSrcIn), .haltIn(haltIn),
        .errIn(errIn), .regWrtData(regWrtData), .regWrtEn(regWrtEn),
        .regWrtAddr(regWrtAddr), .halted(halted), .err(err), .errSticky(errSticky)
`ifdef RETIRE_CNT_EN
        , .retireCnt(retireCnt)
`endif
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          v;
        logic [15:0] alu, mem, pc, instr;
        bit          cond, rw, halt, err;
        logic [2:0]  wr, src;
    } instr_t;

    instr_t m_wb;          // instruction currently sitting in WB
    bit     m_halted;      // a HALT has already left WB
    bit     m_err_seen;    // any err reported since reset
    int     m_retired;     // instructions that have left WB

    logic [OW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        m_wb.v     = 0;
        m_halted   = 0;
        m_err_seen = 0;
        m_retired  = 0;
    endtask

    // What the write port should show for the instruction in WB.
    task automatic push_expected();
        logic [15:0] data;
        bit illegal, en, e;
        data    = 16'h0000;
        illegal = (m_wb.src > 3'd4);
        case (m_wb.src)
            3'd0: data = m_wb.alu;
            3'd1: data = m_wb.mem;
            3'd2: data = m_wb.pc;
            3'd3: data = m_wb.cond ? 16'd1 : 16'd0;
            3'd4: data = m_wb.instr[7:0] * 16'd256;
            default: data = 16'h0000;
        endcase
        if (!m_wb.v) data = 16'h0000;
        en = m_wb.v && m_wb.rw && !m_wb.halt && !illegal && !m_halted;
        e  = m_wb.v && (m_wb.err || illegal);
        if (e) m_err_seen = 1;
`ifdef RETIRE_CNT_EN
        exp_q.push_back({data, en, (m_wb.v ? m_wb.wr : 3'd0), m_halted, e, m_err_seen,
                         CNT_W'(m_retired % (1 << CNT_W))});
`else
        exp_q.push_back({data, en, (m_wb.v ? m_wb.wr : 3'd0), m_halted, e, m_err_seen});
`endif
    endtask

    // One clock edge of the stage as described by its rules.
    task automatic model_edge();
        bit was_halted;
        was_halted = m_halted;
        if (m_wb.v && !was_halted && (!stall || flush || m_wb.halt)) m_retired++;
        if (m_wb.v && m_wb.halt) m_halted = 1;
        if (was_halted || flush) m_wb.v = 0;
        else if (!stall) begin
            m_wb.v     = inValid;
            m_wb.alu   = aluResIn;
            m_wb.mem   = memDataIn;
            m_wb.pc    = nextPcIn;
            m_wb.instr = instrIn;
            m_wb.cond  = condIn;
            m_wb.rw    = regWrtIn;
            m_wb.halt  = haltIn;
            m_wb.err   = errIn;
            m_wb.wr    = writeRegIn;
            m_wb.src   = regWrtSrcIn;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        push_expected();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1 push_expected();
        end
        rst = 1'b0;
    endtask

    task automatic idle();
        inValid = 0; stall = 0; flush = 0; regWrtIn = 0; haltIn = 0; errIn = 0;
        regWrtSrcIn = 3'd0; writeRegIn = 3'd0;
    endtask

    task automatic issue(input bit rw, input logic [2:0] wr, input logic [2:0] src,
                         input logic [15:0] alu, input logic [15:0] mem,
                         input bit halt, input bit e);
        inValid = 1; regWrtIn = rw; writeRegIn = wr; regWrtSrcIn = src;
        aluResIn = alu; memDataIn = mem; haltIn = halt; errIn = e;
        nextPcIn = 16'($urandom); instrIn = 16'($urandom); condIn = 1'($urandom);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [OW-1:0] act, exp;
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
`ifdef RETIRE_CNT_EN
            act = {regWrtData, regWrtEn, regWrtAddr, halted, err, errSticky, retireCnt};
`else
            act = {regWrtData, regWrtEn, regWrtAddr, halted, err, errSticky};
`endif
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL wb_out t=%0t actual=%h expected=%h", $time, act, exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        idle();
        aluResIn = '0; memDataIn = '0; nextPcIn = '0; instrIn = '0; condIn = 0;
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1 push_expected();
        end
        rst = 1'b0;

        // ALU result to r3
        issue(1, 3'd3, 3'd0, 16'h1234, 16'h0000, 0, 0); tick();
        idle(); tick();

        // Load held by a three-cycle stall
        issue(1, 3'd5, 3'd1, 16'h5555, 16'hBEEF, 0, 0); tick();
        stall = 1; inValid = 1; aluResIn = 16'h7777; regWrtSrcIn = 3'd0;
        repeat (3) tick();
        idle(); tick();

        // Flushed capture never writes
        issue(1, 3'd2, 3'd0, 16'hAAAA, 16'h0000, 0, 0); flush = 1; tick();
        idle(); tick();

        // Illegal select raises err and sticks
        issue(1, 3'd4, 3'd6, 16'h1111, 16'h2222, 0, 0); tick();
        idle(); repeat (2) tick();

        // Remaining legal selects and upstream error
        issue(1, 3'd1, 3'd2, 16'h0, 16'h0, 0, 0); tick();
        issue(1, 3'd6, 3'd3, 16'h0, 16'h0, 0, 0); tick();
        issue(1, 3'd7, 3'd4, 16'h0, 16'h0, 0, 1); tick();
        apply_reset();

        // HALT followed by ADD r1: ADD must never write
        issue(0, 3'd0, 3'd0, 16'h0, 16'h0, 1, 0); tick();
        issue(1, 3'd1, 3'd0, 16'h4321, 16'h0, 0, 0); tick();
        issue(1, 3'd2, 3'd0, 16'h8765, 16'h0, 0, 0); tick();
        idle(); repeat (2) tick();
        apply_reset();

        // HALT in WB while stalled still sets halted
        issue(0, 3'd0, 3'd0, 16'h0, 16'h0, 1, 0); tick();
        stall = 1; tick(); tick();
        idle(); tick();
        apply_reset();

`ifdef RETIRE_CNT_EN
        // 17 back-to-back instructions wrap a 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            issue(1, 3'(i), 3'd0, 16'(i), 16'h0, 0, 0); tick();
        end
        idle(); tick();
        apply_reset();
`endif

        // Randomized traffic in blocks separated by resets
        for (int blk = 0; blk < 8; blk++) begin
            for (int c = 0; c < 50; c++) begin
                issue(1'($urandom), 3'($urandom), 3'(($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7)),
                      16'($urandom), 16'($urandom), ($urandom_range(0, 99) < 3), ($urandom_range(0, 9) == 0));
                inValid = ($urandom_range(0, 9) < 8);
                stall   = ($urandom_range(0, 9) < 2);
                flush   = ($urandom_range(0, 9) == 0);
                tick();
            end
            idle();
            apply_reset();
        end

        idle(); tick();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain actual=%0d entries left required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
